// File: rtl/id_ex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_ctrl
//
// Purpose:
//   Hazard and flow controller for the front of the pipeline. It compares the
//   source registers of the instruction in ID against the destination of the
//   instruction in EX. From that comparison and the EX control fields it
//   produces the hold, bubble and flush commands for the PC, IF/ID and ID/EX
//   registers. The hazards handled are load-use, taken branch/jump, memory
//   back-pressure and HLT.
//
// Configuration:
//   FLUSH_CYCLES        cycles of IF/ID flush + ID/EX bubble per taken branch
//                       (1..15)
//   CNT_W               width of the performance counters
//   HAZARD_PERF_CNT_EN  macro; when defined, stall_cnt/flush_cnt count events.
//                       When undefined, both outputs are tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ID_src_reg1/2       source registers of the ID instruction
//   ID_src1/2_used      ID instruction actually reads that source
//   EX_dst_reg          destination register of the EX instruction
//   EX_wb_we            EX instruction writes the register file
//   EX_wb_mem_sel       EX instruction is a load
//   EX_branch_taken     EX redirects the PC
//   EX_hlt              EX instruction is HLT
//   mem_busy            data memory stall, freezes the whole pipe
//   pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble
//                       per-stage flow commands (combinational)
//   halted              sticky halt indication (registered)
//   stall_cnt           cycles with load-use stall or mem_busy freeze
//   flush_cnt           cycles with if_id_flush asserted
// -----------------------------------------------------------------------------
module id_ex_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_src_reg1,
  input  logic [4:0]       ID_src_reg2,
  input  logic             ID_src1_used,
  input  logic             ID_src2_used,
  input  logic [4:0]       EX_dst_reg,
  input  logic             EX_wb_we,
  input  logic             EX_wb_mem_sel,
  input  logic             EX_branch_taken,
  input  logic             EX_hlt,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Remaining flush cycles after the one in which the branch is seen in EX.
  localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_fl_cnt;
  logic       r_halted;

  logic w_lu;
  logic w_lu_stall;
  logic w_pc_hold;
  logic w_if_id_hold;
  logic w_if_id_flush;
  logic w_id_ex_hold;
  logic w_id_ex_bubble;

  // Load-use hazard: a load in EX whose destination matches a source that
  // the ID instruction actually reads. r0 is hard-wired, so it never hazards.
  assign w_lu = EX_wb_mem_sel & EX_wb_we & (EX_dst_reg != 5'd0) &
                ((ID_src1_used & (ID_src_reg1 == EX_dst_reg)) |
                 (ID_src2_used & (ID_src_reg2 == EX_dst_reg)));

  // Flow commands, evaluated in strict priority order.
  always_comb begin
    w_pc_hold      = 1'b0;
    w_if_id_hold   = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_hold   = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_lu_stall     = 1'b0;
    if (rst_n) begin
      if (r_state == ST_HALT) begin
        w_pc_hold      = 1'b1;
        w_if_id_hold   = 1'b1;
        w_id_ex_bubble = 1'b1;
      end else if (mem_busy) begin
        // Full freeze: nothing moves, so nothing may be flushed or bubbled.
        w_pc_hold    = 1'b1;
        w_if_id_hold = 1'b1;
        w_id_ex_hold = 1'b1;
      end else if (EX_hlt) begin
        w_pc_hold      = 1'b1;
        w_if_id_hold   = 1'b1;
        w_id_ex_bubble = 1'b1;
      end else if ((r_state == ST_FLUSH) || EX_branch_taken) begin
        // PC is loading the branch target, so it must not be held.
        w_if_id_flush  = 1'b1;
        w_id_ex_bubble = 1'b1;
      end else if (w_lu) begin
        // One bubble is enough: next cycle EX holds it and lu drops.
        w_pc_hold      = 1'b1;
        w_if_id_hold   = 1'b1;
        w_id_ex_bubble = 1'b1;
        w_lu_stall     = 1'b1;
      end
    end
  end

  assign pc_hold      = w_pc_hold;
  assign if_id_hold   = w_if_id_hold;
  assign if_id_flush  = w_if_id_flush;
  assign id_ex_hold   = w_id_ex_hold;
  assign id_ex_bubble = w_id_ex_bubble;
  assign halted       = r_halted;

  // State machine. mem_busy freezes both the state and the flush countdown,
  // so a branch or HLT waiting in EX is handled once the memory is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_fl_cnt <= 4'd0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!mem_busy) begin
            if (EX_hlt) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else if (EX_branch_taken && (FLUSH_CYCLES > 1)) begin
              r_state  <= ST_FLUSH;
              r_fl_cnt <= FL_INIT;
            end
          end
        end
        ST_FLUSH: begin
          if (!mem_busy) begin
            if (EX_hlt) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
              r_fl_cnt <= 4'd0;
            end else if (r_fl_cnt <= 4'd1) begin
              r_state  <= ST_RUN;
              r_fl_cnt <= 4'd0;
            end else begin
              r_fl_cnt <= r_fl_cnt - 4'd1;
            end
          end
        end
        ST_HALT: begin
          // Only reset leaves HALT.
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= ST_RUN;
          r_fl_cnt <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_evt;

  // A mem_busy cycle counts as a stall even without a load-use hazard.
  // Cycles spent halted are not counted.
  assign w_stall_evt = (r_state != ST_HALT) && (mem_busy || w_lu_stall);

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_if_id_flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  // The stall qualifier only feeds the counters.
  logic w_unused_lu_stall;
  assign w_unused_lu_stall = w_lu_stall;

  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
module tb_id_ex_hazard_ctrl;

  localparam int CNT_W = 16;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [4:0]       ID_src_reg1;
  logic [4:0]       ID_src_reg2;
  logic             ID_src1_used;
  logic             ID_src2_used;
  logic [4:0]       EX_dst_reg;
  logic             EX_wb_we;
  logic             EX_wb_mem_sel;
  logic             EX_branch_taken;
  logic             EX_hlt;
  logic             mem_busy;
  logic             pc_hold;
  logic             if_id_hold;
  logic             if_id_flush;
  logic             id_ex_hold;
  logic             id_ex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, halted}
  logic [5:0] outs;
  assign outs = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, halted};

  localparam logic [5:0] O_IDLE   = 6'b000000;
  localparam logic [5:0] O_STALL  = 6'b110010;
  localparam logic [5:0] O_FLUSH  = 6'b001010;
  localparam logic [5:0] O_FREEZE = 6'b110100;
  localparam logic [5:0] O_HALT   = 6'b110011;

  id_ex_hazard_ctrl #(
    .FLUSH_CYCLES(2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID_src_reg1    (ID_src_reg1),
    .ID_src_reg2    (ID_src_reg2),
    .ID_src1_used   (ID_src1_used),
    .ID_src2_used   (ID_src2_used),
    .EX_dst_reg     (EX_dst_reg),
    .EX_wb_we       (EX_wb_we),
    .EX_wb_mem_sel  (EX_wb_mem_sel),
    .EX_branch_taken(EX_branch_taken),
    .EX_hlt         (EX_hlt),
    .mem_busy       (mem_busy),
    .pc_hold        (pc_hold),
    .if_id_hold     (if_id_hold),
    .if_id_flush    (if_id_flush),
    .id_ex_hold     (id_ex_hold),
    .id_ex_bubble   (id_ex_bubble),
    .halted         (halted),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value: real count when counters are built, else 0.
  function automatic logic [31:0] ce(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("[%0t] %-16s obs=%0h exp=%0h ok", $time, tag, obs, exp);
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ID_src_reg1     = 5'd0;
    ID_src_reg2     = 5'd0;
    ID_src1_used    = 1'b0;
    ID_src2_used    = 1'b0;
    EX_dst_reg      = 5'd0;
    EX_wb_we        = 1'b0;
    EX_wb_mem_sel   = 1'b0;
    EX_branch_taken = 1'b0;
    EX_hlt          = 1'b0;
    mem_busy        = 1'b0;
  endtask

  // Load of r5 in EX, ID reads r5 as src2.
  task automatic load_use_r5();
    EX_wb_mem_sel = 1'b1;
    EX_wb_we      = 1'b1;
    EX_dst_reg    = 5'd5;
    ID_src_reg2   = 5'd5;
    ID_src2_used  = 1'b1;
  endtask

  initial begin
    clr();
    rst_n           = 1'b0;
    mem_busy        = 1'b1;
    EX_branch_taken = 1'b1;
    #3;
    check("reset_outs", 32'(outs), 32'(O_IDLE));
    check("reset_stall", 32'(stall_cnt), 32'd0);
    check("reset_flush", 32'(flush_cnt), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    clr();
    #3;
    check("idle", 32'(outs), 32'(O_IDLE));

    // Load-use stall lasts one cycle, then EX holds the bubble.
    tick(); load_use_r5(); #3;
    check("lu_stall", 32'(outs), 32'(O_STALL));
    check("lu_stall_cnt0", 32'(stall_cnt), ce(0));
    tick(); clr(); #3;
    check("lu_cleared", 32'(outs), 32'(O_IDLE));
    check("lu_stall_cnt1", 32'(stall_cnt), ce(1));

    // r0 never hazards.
    tick();
    EX_wb_mem_sel = 1'b1; EX_wb_we = 1'b1; EX_dst_reg = 5'd0;
    ID_src_reg1 = 5'd0; ID_src1_used = 1'b1; ID_src2_used = 1'b1;
    #3;
    check("r0_no_hazard", 32'(outs), 32'(O_IDLE));
    // Matching source that is not read does not hazard.
    tick(); clr();
    EX_wb_mem_sel = 1'b1; EX_wb_we = 1'b1; EX_dst_reg = 5'd7;
    ID_src_reg1 = 5'd7; ID_src1_used = 1'b0;
    ID_src_reg2 = 5'd3; ID_src2_used = 1'b1;
    #3;
    check("unused_src", 32'(outs), 32'(O_IDLE));

    // Branch pulse: two flush cycles with FLUSH_CYCLES = 2.
    tick(); clr(); EX_branch_taken = 1'b1; #3;
    check("br_c0", 32'(outs), 32'(O_FLUSH));
    check("br_fcnt0", 32'(flush_cnt), ce(0));
    tick(); EX_branch_taken = 1'b0; #3;
    check("br_c1", 32'(outs), 32'(O_FLUSH));
    check("br_fcnt1", 32'(flush_cnt), ce(1));
    tick(); #3;
    check("br_done", 32'(outs), 32'(O_IDLE));
    check("br_fcnt2", 32'(flush_cnt), ce(2));

    // Branch together with load-use: branch wins, no stall counted.
    tick(); load_use_r5(); EX_branch_taken = 1'b1; #3;
    check("br_lu", 32'(outs), 32'(O_FLUSH));
    tick(); clr(); #3;
    check("br_lu_c1", 32'(outs), 32'(O_FLUSH));
    check("br_lu_stall", 32'(stall_cnt), ce(1));
    tick(); #3;
    check("br_lu_done", 32'(outs), 32'(O_IDLE));
    check("br_lu_fcnt", 32'(flush_cnt), ce(4));

    // mem_busy inside FLUSH freezes the countdown.
    tick(); EX_branch_taken = 1'b1; #3;
    check("fb_c0", 32'(outs), 32'(O_FLUSH));
    tick(); EX_branch_taken = 1'b0; mem_busy = 1'b1; #3;
    check("fb_busy", 32'(outs), 32'(O_FREEZE));
    tick(); mem_busy = 1'b0; #3;
    check("fb_resume", 32'(outs), 32'(O_FLUSH));
    check("fb_stall", 32'(stall_cnt), ce(2));
    tick(); #3;
    check("fb_end", 32'(outs), 32'(O_IDLE));
    check("fb_fcnt", 32'(flush_cnt), ce(6));

    // mem_busy for 3 cycles with HLT waiting in EX.
    for (int i = 0; i < 3; i++) begin
      tick(); mem_busy = 1'b1; EX_hlt = 1'b1; #3;
      check("hlt_busy", 32'(outs), 32'(O_FREEZE));
      check("hlt_busy_stall", 32'(stall_cnt), ce(2 + i));
    end
    tick(); mem_busy = 1'b0; #3;
    check("hlt_bubble", 32'(outs), 32'(O_STALL));
    check("hlt_bub_stall", 32'(stall_cnt), ce(5));
    tick(); EX_hlt = 1'b0; #3;
    check("halted", 32'(outs), 32'(O_HALT));
    tick(); load_use_r5(); mem_busy = 1'b1; #3;
    check("halt_sticky", 32'(outs), 32'(O_HALT));
    tick(); clr(); #3;
    check("halt_sticky2", 32'(outs), 32'(O_HALT));
    check("halt_no_stall", 32'(stall_cnt), ce(5));

    // Asynchronous reset out of HALT.
    #2; rst_n = 1'b0; #1;
    check("rst_halt", 32'(outs), 32'(O_IDLE));
    check("rst_halt_stall", 32'(stall_cnt), 32'd0);
    tick(); rst_n = 1'b1; #3;
    check("post_rst_run", 32'(outs), 32'(O_IDLE));

    // Asynchronous reset in the middle of FLUSH.
    tick(); EX_branch_taken = 1'b1; #3;
    check("rf_c0", 32'(outs), 32'(O_FLUSH));
    tick(); EX_branch_taken = 1'b0; #3;
    check("rf_c1", 32'(outs), 32'(O_FLUSH));
    #1; rst_n = 1'b0; #1;
    check("rst_flush", 32'(outs), 32'(O_IDLE));
    check("rst_flush_fcnt", 32'(flush_cnt), 32'd0);
    tick(); rst_n = 1'b1; #3;
    check("run_after_rst", 32'(outs), 32'(O_IDLE));
    check("run_rst_stall", 32'(stall_cnt), 32'd0);
    check("run_rst_fcnt", 32'(flush_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_ctrl.md
Name: id_ex_hazard_ctrl

Overview:
Pipeline hazard and flow controller that drives the hold/bubble/flush inputs of the IF, IF/ID and ID/EX stages. It reads the source registers of the instruction in ID and the control fields of the instruction currently in EX. It detects load-use hazards, taken branches/jumps resolved in EX, memory back-pressure and halt, and turns them into per-stage stall and flush commands. It also keeps optional stall/flush performance counters.

Parameters:
FLUSH_CYCLES, 1, total cycles id_ex_bubble/if_id_flush stay asserted per taken branch (1..15)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ID_src_reg1  in  5  first source register of instruction in ID
ID_src_reg2  in  5  second source register of instruction in ID
ID_src1_used  in  1  ID instruction reads src1
ID_src2_used  in  1  ID instruction reads src2
EX_dst_reg  in  5  destination register of instruction in EX
EX_wb_we  in  1  EX instruction writes the register file
EX_wb_mem_sel  in  1  EX instruction is a load (writeback from memory)
EX_branch_taken  in  1  EX resolved a taken branch/jump (PC redirect)
EX_hlt  in  1  EX instruction is HLT
mem_busy  in  1  data memory not ready; whole pipe must freeze
pc_hold  out  1  hold PC
if_id_hold  out  1  hold IF/ID register
if_id_flush  out  1  load NOP into IF/ID
id_ex_hold  out  1  hold ID/EX register
id_ex_bubble  out  1  load all-zero controls into ID/EX
halted  out  1  core halted (sticky)
stall_cnt  out  CNT_W  cycles with load-use stall or mem_busy freeze
flush_cnt  out  CNT_W  cycles with branch flush asserted

Behaviour:
- States: RUN, FLUSH, HALT. Reset state RUN; flush counter fl_cnt = 0.
- Reset values: all outputs are 0 while rst_n = 0, including the counters. halted is registered. The other control outputs are combinational from state and inputs, and are forced to 0 during reset.
- Load-use hazard: lu = EX_wb_mem_sel & EX_wb_we & (EX_dst_reg != 0) & ((ID_src1_used & ID_src1 == EX_dst_reg) | (ID_src2_used & ID_src2 == EX_dst_reg)). Register 0 never causes a hazard.
- Priority, highest first: HALT state > mem_busy > EX_hlt > FLUSH state/EX_branch_taken > lu.
- HALT: pc_hold = if_id_hold = id_ex_bubble = 1, halted = 1. The block leaves HALT only on reset.
- mem_busy = 1 (RUN or FLUSH): pc_hold = if_id_hold = id_ex_hold = 1, no bubble and no flush. fl_cnt is frozen. A pending branch or HLT in EX is acted on in the first cycle after mem_busy falls.
- EX_hlt in RUN with mem_busy = 0: pc_hold = if_id_hold = id_ex_bubble = 1 in the same cycle; next state HALT; halted = 1 from the next edge.
- EX_branch_taken in RUN with mem_busy = 0: if_id_flush = id_ex_bubble = 1 in the same cycle. No holds; the PC loads the target.
  - If FLUSH_CYCLES > 1: next state FLUSH with fl_cnt = FLUSH_CYCLES-1.
  - FLUSH keeps if_id_flush = id_ex_bubble = 1 and decrements fl_cnt each non-busy cycle. It returns to RUN when fl_cnt reaches 1 → 0.
  - lu and a new EX_branch_taken are ignored while in FLUSH, since EX holds a bubble.
- lu in RUN (nothing higher active): pc_hold = if_id_hold = id_ex_bubble = 1 for exactly one cycle. In the following cycle EX holds the bubble, so lu clears without further action.
- A simultaneous branch and lu: the branch wins and no stall is produced.
- Counters: stall_cnt increments in each cycle with (lu stall or mem_busy) outside HALT. flush_cnt increments in each cycle with if_id_flush = 1. Both saturate at all-ones.
- Asynchronous reset mid-FLUSH or in HALT returns the block to RUN and clears the counters immediately.

Optional Feature:
HAZARD_PERF_CNT_EN. When defined, stall_cnt and flush_cnt are implemented as above. When undefined, the counter registers are omitted and both outputs are tied to 0; all other behaviour is identical.

Test Plan:
- Load r5 in EX (EX_wb_mem_sel = EX_wb_we = 1, EX_dst_reg = 5), ID_src2 = 5 used → pc_hold/if_id_hold/id_ex_bubble = 1 for exactly 1 cycle; stall_cnt 0→1.
- Same as above but EX_dst_reg = 0 and ID_src1 = 0 → no stall; all outputs 0.
- FLUSH_CYCLES = 2, EX_branch_taken pulse for 1 cycle → if_id_flush = id_ex_bubble = 1 for 2 consecutive cycles, no holds; flush_cnt = 2.
- EX_branch_taken with lu in the same cycle → flush only, pc_hold = 0; stall_cnt unchanged.
- mem_busy held 3 cycles with EX_hlt = 1 → pc_hold/if_id_hold/id_ex_hold = 1 for 3 cycles; in the next cycle bubble asserts, then halted = 1 and stays until rst_n = 0.
- rst_n low for 1 cycle during FLUSH → all outputs 0 immediately; after release, RUN with counters = 0.
